// File: rtl/input_mapper_pkg.sv
// Shared definitions for input_mapper: ps2 scancodes ({extended, code}),
// joystick word bit positions, the coin FSM encoding and the static keymap.
package input_mapper_pkg;

  // P1 directions (extended codes) and buttons
  localparam logic [8:0] KEY_UP      = 9'h175;
  localparam logic [8:0] KEY_DOWN    = 9'h172;
  localparam logic [8:0] KEY_LEFT    = 9'h16B;
  localparam logic [8:0] KEY_RIGHT   = 9'h174;
  localparam logic [8:0] KEY_P1_B1   = 9'h014;  // LCtrl
  localparam logic [8:0] KEY_P1_B2   = 9'h011;  // LAlt
  localparam logic [8:0] KEY_P1_B3   = 9'h029;  // Space
  localparam logic [8:0] KEY_P1_B4   = 9'h012;  // LShift
  // P2 directions and buttons
  localparam logic [8:0] KEY_P2_UP    = 9'h02D; // R
  localparam logic [8:0] KEY_P2_DOWN  = 9'h02B; // F
  localparam logic [8:0] KEY_P2_LEFT  = 9'h023; // D
  localparam logic [8:0] KEY_P2_RIGHT = 9'h034; // G
  localparam logic [8:0] KEY_P2_B1    = 9'h01C; // A
  localparam logic [8:0] KEY_P2_B2    = 9'h01B; // S
  localparam logic [8:0] KEY_P2_B3    = 9'h015; // Q
  localparam logic [8:0] KEY_P2_B4    = 9'h01D; // W
  // Start keys 1..4, coin keys 5..8
  localparam logic [8:0] KEY_START_1 = 9'h016;
  localparam logic [8:0] KEY_START_2 = 9'h01E;
  localparam logic [8:0] KEY_START_3 = 9'h026;
  localparam logic [8:0] KEY_START_4 = 9'h025;
  localparam logic [8:0] KEY_COIN_1  = 9'h02E;
  localparam logic [8:0] KEY_COIN_2  = 9'h036;
  localparam logic [8:0] KEY_COIN_3  = 9'h03D;
  localparam logic [8:0] KEY_COIN_4  = 9'h03E;

  // Joystick word bit positions
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_BTN0  = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, HOLD = 2'd2} coin_state_t;

  // Joystick word width for a given button count
  function automatic int jw(input int nb);
    return 4 + nb + 2;
  endfunction

  // Key bound to joystick-word bit j of player p: {bound, ext, code}
  function automatic logic [9:0] key_map(input int p, input int j, input int nb);
    logic [9:0] m;
    m = '0;
    if (j == 5 + nb) begin
      case (p)
        0: m = {1'b1, KEY_COIN_1};
        1: m = {1'b1, KEY_COIN_2};
        2: m = {1'b1, KEY_COIN_3};
        3: m = {1'b1, KEY_COIN_4};
        default: m = '0;
      endcase
    end else if (j == 4 + nb) begin
      case (p)
        0: m = {1'b1, KEY_START_1};
        1: m = {1'b1, KEY_START_2};
        2: m = {1'b1, KEY_START_3};
        3: m = {1'b1, KEY_START_4};
        default: m = '0;
      endcase
    end else if (p == 0) begin
      case (j)
        JOY_RIGHT:    m = {1'b1, KEY_RIGHT};
        JOY_LEFT:     m = {1'b1, KEY_LEFT};
        JOY_DOWN:     m = {1'b1, KEY_DOWN};
        JOY_UP:       m = {1'b1, KEY_UP};
        JOY_BTN0:     m = {1'b1, KEY_P1_B1};
        JOY_BTN0 + 1: m = {1'b1, KEY_P1_B2};
        JOY_BTN0 + 2: m = {1'b1, KEY_P1_B3};
        JOY_BTN0 + 3: m = {1'b1, KEY_P1_B4};
        default:      m = '0;
      endcase
    end else if (p == 1) begin
      case (j)
        JOY_RIGHT:    m = {1'b1, KEY_P2_RIGHT};
        JOY_LEFT:     m = {1'b1, KEY_P2_LEFT};
        JOY_DOWN:     m = {1'b1, KEY_P2_DOWN};
        JOY_UP:       m = {1'b1, KEY_P2_UP};
        JOY_BTN0:     m = {1'b1, KEY_P2_B1};
        JOY_BTN0 + 1: m = {1'b1, KEY_P2_B2};
        JOY_BTN0 + 2: m = {1'b1, KEY_P2_B3};
        JOY_BTN0 + 3: m = {1'b1, KEY_P2_B4};
        default:      m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/input_mapper_coin_pulse.sv
// coin_pulse: turns a raw coin level into one fixed-width pulse per press.
// A press that outlasts the pulse parks in HOLD until the coin is released.
module coin_pulse
  import input_mapper_pkg::*;
#(
  parameter int CYCLES = 1200000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CYCLES - 1);

  coin_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          raw_q;

  // State, counter, edge-detect and the glitch-free registered pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      raw_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      raw_q <= raw;
      pulse <= (state_nxt == PULSE);
    end
  end

  // Next state: rising edge starts the pulse, counter times it, HOLD waits for release
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (raw && !raw_q) begin
          state_nxt = PULSE;
          cnt_nxt   = RELOAD;
        end
        PULSE: if (cnt == '0) state_nxt = HOLD;
               else           cnt_nxt   = cnt - CW'(1);
        HOLD: if (!raw) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/input_mapper.sv
// input_mapper: ps2 key decode merged with HPS joysticks, SOCD resolution,
// coin shaping and registered per-player control words.
// Optional autofire on masked buttons: define INPUT_MAPPER_AUTOFIRE_EN.
module input_mapper
  import input_mapper_pkg::*;
#(
  parameter int NUM_PLAYERS       = 2,
  parameter int NUM_BUTTONS       = 2,
  parameter int COIN_PULSE_CYCLES = 1200000,
  parameter int SOCD_NEUTRAL      = 1
`ifdef INPUT_MAPPER_AUTOFIRE_EN
  ,
  parameter int AUTOFIRE_HALF     = 2400000
`endif
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   clear,
  input  logic [10:0]                            ps2_key,
  input  logic [NUM_PLAYERS*(NUM_BUTTONS+6)-1:0] joystick,
`ifdef INPUT_MAPPER_AUTOFIRE_EN
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0]     autofire_mask,
`endif
  output logic [NUM_PLAYERS*4-1:0]               player_dir,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0]     player_btn,
  output logic [NUM_PLAYERS-1:0]                 start,
  output logic [NUM_PLAYERS-1:0]                 coin
);

  localparam int JW = jw(NUM_BUTTONS);

  logic                                     old_toggle;
  logic [NUM_PLAYERS-1:0][JW-1:0]           key_q, key_eff, joy, raw;
  logic [NUM_PLAYERS-1:0][3:0]              dir_d;
  logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0]  btn_raw, btn_d;
  logic [NUM_PLAYERS-1:0]                   start_d, lr_kill, ud_kill;

  assign joy     = joystick;
  // clear hides key state in the same cycle it wipes it, so outputs drop at once
  assign key_eff = clear ? '0 : key_q;
  assign raw     = key_eff | joy;

  // Key state: a toggle edge writes 'pressed' into the reg bound to {ext, code}
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      old_toggle <= 1'b0;
      key_q      <= '0;
    end else begin
      old_toggle <= ps2_key[10];
      if (clear) begin
        key_q <= '0;
      end else if (ps2_key[10] != old_toggle) begin
        for (int p = 0; p < NUM_PLAYERS; p++)
          for (int j = 0; j < JW; j++)
            if (key_map(p, j, NUM_BUTTONS) == {1'b1, ps2_key[8:0]})
              key_q[p][j] <= ps2_key[9];
      end
    end
  end

  // Opposing-direction resolution and unpacking of the merged word
  always_comb begin
    dir_d   = '0;
    btn_raw = '0;
    start_d = '0;
    lr_kill = '0;
    ud_kill = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      lr_kill[p] = (SOCD_NEUTRAL != 0) && raw[p][JOY_LEFT] && raw[p][JOY_RIGHT];
      ud_kill[p] = (SOCD_NEUTRAL != 0) && raw[p][JOY_UP]   && raw[p][JOY_DOWN];
      dir_d[p]   = {raw[p][JOY_UP]    & ~ud_kill[p], raw[p][JOY_DOWN] & ~ud_kill[p],
                    raw[p][JOY_RIGHT] & ~lr_kill[p], raw[p][JOY_LEFT] & ~lr_kill[p]};
      btn_raw[p] = raw[p][JOY_BTN0 +: NUM_BUTTONS];
      start_d[p] = raw[p][JOY_BTN0 + NUM_BUTTONS];
    end
  end

`ifdef INPUT_MAPPER_AUTOFIRE_EN
  localparam int AW = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;
  localparam logic [AW-1:0] AF_RELOAD = AW'(AUTOFIRE_HALF - 1);

  logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0] af_mask;
  assign af_mask = autofire_mask;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_af
    logic [AW-1:0]          cnt;
    logic                   phase, phase_nxt, press;
    logic [NUM_BUTTONS-1:0] btn_q;

    // Any new press of a masked button restarts the square wave in its high half
    assign press     = |(af_mask[p] & btn_raw[p] & ~btn_q);
    assign phase_nxt = press ? 1'b1 : ((cnt == '0) ? ~phase : phase);
    assign btn_d[p]  = btn_raw[p] & (~af_mask[p] | {NUM_BUTTONS{phase_nxt}});

    // Per-player phase counter
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= '0;
        phase <= 1'b0;
        btn_q <= '0;
      end else begin
        btn_q <= btn_raw[p];
        phase <= phase_nxt;
        if (press || cnt == '0) cnt <= AF_RELOAD;
        else                    cnt <= cnt - AW'(1);
      end
    end
  end
`else
  assign btn_d = btn_raw;
`endif

  // Registered control words
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      player_dir <= '0;
      player_btn <= '0;
      start      <= '0;
    end else begin
      player_dir <= dir_d;
      player_btn <= btn_d;
      start      <= start_d;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    coin_pulse #(.CYCLES(COIN_PULSE_CYCLES)) u_coin (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .raw     (raw[p][JW-1]),
      .pulse   (coin[p])
    );
  end

endmodule

// File: doc/input_mapper.md
Name: input_mapper

Overview:
- Parametrised keyboard/joystick input front-end for arcade cores.
- Decodes the MiSTer ps2_key stream into per-player key state and ORs it with the HPS joysticks.
- Shapes coin inputs into fixed-width pulses, resolves opposing directions, and emits registered per-player control words.
- Sits between hps_io and the game core, replacing ad-hoc key decoding in each emu top level.

Parameters:
- NUM_PLAYERS, 2, player count, 1..4.
- NUM_BUTTONS, 2, fire buttons per player, 1..4.
- COIN_PULSE_CYCLES, 1200000, coin output high time in clk cycles (25 ms at 48 MHz); must be >=1.
- SOCD_NEUTRAL, 1, 1: opposing directions both held resolve to neither; 0: pass through unchanged.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of key state and coin pulses (e.g. during ROM download)
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
- joystick  in  NUM_PLAYERS*(4+NUM_BUTTONS+2)  per-player HPS joystick word, player p at offset p*JW
- player_dir  out  NUM_PLAYERS*4  per player {up,down,right,left}
- player_btn  out  NUM_PLAYERS*NUM_BUTTONS  per-player buttons, bit 0 = button 1
- start  out  NUM_PLAYERS  start buttons
- coin  out  NUM_PLAYERS  shaped coin pulses

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Joystick word layout (JW = 4+NUM_BUTTONS+2):
  - [0] right, [1] left, [2] down, [3] up
  - [4+i] button i
  - [4+NUM_BUTTONS] start
  - [5+NUM_BUTTONS] coin
- Reset: all key regs, old_toggle, coin counters and all outputs = 0.
- Key decode:
  - old_toggle <= ps2_key[10] every cycle.
  - When ps2_key[10] != old_toggle, the key reg matching {extended, scancode} <= pressed.
  - Unmapped codes are ignored.
  - The extended bit must match: E0-75 is P1 up; plain 75 (keypad 8) is unmapped.
- Keymap:
  - P1: arrows (E0 75/72/6B/74); buttons LCtrl 14, LAlt 11, Space 29, LShift 12.
  - P2: R 2D up, F 2B down, D 23 left, G 34 right; buttons A 1C, S 1B, Q 15, W 1D.
  - Start for P1..P4: keys 1..4 (16, 1E, 26, 25).
  - Coin for P1..P4: keys 5..8 (2E, 36, 3D, 3E).
  - Keys for players >= NUM_PLAYERS and buttons >= NUM_BUTTONS are not instantiated.
- Merge: raw = key | joystick bit, per signal.
- Direction resolution (SOCD_NEUTRAL=1):
  - left&right both held: both 0.
  - up&down both held: both 0.
  - Applied after the merge.
- Outputs are registered.
  - Latency, joystick change to output: 1 cycle.
  - Latency, ps2 toggle edge to output: 2 cycles.
- Coin shaping, per player:
  - IDLE: on raw coin rising edge, go to PULSE; coin=1; counter=COIN_PULSE_CYCLES-1.
  - PULSE: decrement; at 0, go to HOLD; coin=0.
  - HOLD: wait until raw coin=0, then IDLE.
  - Holding coin yields exactly one pulse.
  - Edges arriving during PULSE are ignored.
  - A release-and-repress during PULSE yields no second pulse unless raw is high on entry to IDLE after HOLD… more precisely, HOLD exits only when raw=0, then the next rise triggers.
- clear: all key regs=0 and all coin FSMs forced to IDLE with coin=0 on the next edge. clear has priority over a simultaneous ps2 event.
- Reset mid-pulse: coin drops immediately (asynchronous).

Optional Feature:
- Macro: INPUT_MAPPER_AUTOFIRE_EN.
- When defined:
  - Extra inputs autofire_mask [NUM_PLAYERS*NUM_BUTTONS] and parameter AUTOFIRE_HALF, default 2400000.
  - A masked, held button outputs a square wave: high for AUTOFIRE_HALF cycles, then low for AUTOFIRE_HALF, repeating.
  - The per-player phase counter restarts high on each press of any masked button; release forces output 0 within 1 cycle.
- When undefined: no extra ports; buttons pass through as raw.

Decomposition:
- Package input_mapper_pkg holds:
  - scancode constants (KEY_UP … KEY_COIN_4)
  - joystick bit indices (JOY_RIGHT, JOY_LEFT, JOY_DOWN, JOY_UP, JOY_BTN0)
  - function jw(NUM_BUTTONS)
  - coin FSM state enum {IDLE, PULSE, HOLD}
- Sub-module coin_pulse: one instance per player; ports clk, reset_n, clear, raw, pulse; parameter CYCLES.

Test Plan:
- toggle ps2_key with {pressed=1, ext=1, 0x6B} -> player_dir[0]=1 for P1 two cycles later. Same code with ext=0 -> no change.
- joystick P2 bits 0 and 1 both set, SOCD_NEUTRAL=1 -> P2 left=right=0. With SOCD_NEUTRAL=0 -> both 1.
- COIN_PULSE_CYCLES=4, hold key 5 for 20 cycles -> coin[0] high exactly 4 cycles, one pulse. Release, repress -> second 4-cycle pulse.
- Coin rises, clear asserted on cycle 2 of the pulse -> coin[0]=0 next cycle; later press -> fresh full pulse.
- Press LCtrl via ps2, then assert clear -> player_btn[0]=0 next cycle despite no release event.
- AUTOFIRE_EN, AUTOFIRE_HALF=3, mask P1 btn0, hold 12 cycles -> output pattern 111000111000; release -> 0 within 1 cycle.
